load_store_unit32: RTL
======================

Name: load_store_unit32

Overview:
- Sits directly upstream of data_memory32, between the execute stage and the word-wide data memory.
- Accepts one RV32I load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and checks alignment and range.
- Converts byte addresses to word indices and does read-modify-write for sub-word stores, since the memory has only a whole-word write enable.
- Returns sign/zero-extended load data through a single-cycle response pulse.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory; word indices >= DEPTH are out of range.
- n, 32, data/address width.

Ports:
- clk  in  1  rising-edge clock, shared with data_memory32.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  n  byte address.
- req_wdata  in  n  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  n  extended load data; 0 for stores and faults.
- resp_misaligned  out  1  valid with resp_valid.
- resp_oob  out  1  valid with resp_valid.
- mem_addr  out  n  word index = {2'b00, req_addr[n-1:2]}.
- mem_write_enable  out  1  to data_memory32.write_enable.
- mem_write_data  out  n  to data_memory32.write_data.
- mem_read_data  in  n  from data_memory32.read_data; combinational read of mem_addr.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE. Reset takes effect immediately, independent of clk.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready = 1. Handshake when req_valid = 1 at a clk edge. On handshake, latch req_write/funct3/addr/wdata and load mem_addr.
- Checks at accept:
  - misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - illegal funct3 (011, 110, 111; or 100/101 with req_write = 1): treated as misaligned.
  - out of range: word index >= DEPTH gives oob.
  - If misaligned and oob both apply, both flags are set.
  - Any fault goes to RESP with no memory access.
- Next state at accept (no fault):
  - load goes to READ.
  - SW goes to WRITE, with mem_write_data = req_wdata.
  - SB/SH goes to READ.
- READ (one cycle): capture mem_read_data into an internal word register at the exit edge.
  - Load: extract the lane by addr[1:0]/addr[1], sign- or zero-extend, register into resp_rdata, then go to RESP.
  - SB/SH: merge the new byte/half into the captured word (other lanes unchanged), register into mem_write_data, then go to WRITE.
- WRITE (one cycle): mem_write_enable = 1, so memory commits at the exit edge; then go to RESP.
- RESP (one cycle): resp_valid = 1; flags and resp_rdata valid; req_ready = 0; next state IDLE. Response has no backpressure.
- mem_write_enable is 1 only in WRITE. mem_addr and mem_write_data hold stable for the whole transaction.
- Latency from accept edge to the cycle in which resp_valid is high:
  - fault: 1 cycle.
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Back-to-back throughput: one request per (latency + 1) cycles.
- req_valid while busy is ignored, not queued.
- Reset asserted in IDLE/READ: no write occurs. Reset asserted in WRITE: mem_write_enable falls immediately, and no write commits unless a clk edge precedes the reset.
- resp_rdata and the flags return to 0 the cycle after RESP.

Decomposition:
- Package lsu32_pkg holds:
  - funct3 constants LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - state encoding constants for IDLE/READ/WRITE/RESP.
  - DEPTH default.
- One combinational sub-module, lsu_lane32: load lane select/extend and store-lane merge, both driven by funct3 and addr[1:0]. The FSM and registers stay in the top module.

Test Plan:
- Reset check: after reset with memory zeroed, req_ready = 1, resp_valid = 0, mem_write_enable = 0, mem_addr = 0. Then LW 0x0 gives resp_rdata = 0x00000000, 2 cycles after accept.
- Full-word store/load: SW addr 0x10, data 0xDEADBEEF gives exactly one mem_write_enable cycle with mem_addr = 4 and mem_write_data = 0xDEADBEEF; resp_valid 2 cycles after accept. Then LW 0x10 gives 0xDEADBEEF.
- Byte store/loads: SB 0x13, data 0x000000A5 gives a write of 0xA5ADBEEF, 3 cycles after accept. Then LB 0x13 gives 0xFFFFFFA5, and LBU 0x13 gives 0x000000A5.
- Halfword store/loads: SH 0x10, data 0x00001234 gives 0xA5AD1234. Then LH 0x12 gives 0xFFFFA5AD, and LHU 0x12 gives 0x0000A5AD.
- Faults: LW 0x11 gives resp_misaligned = 1 and resp_rdata = 0 one cycle after accept, with no mem_write_enable. SW 0x1000 gives resp_oob = 1, and a following LW 0x0 is still 0.
- Reset mid-operation: assert rst_n = 0 while in READ of SB 0x10. All outputs go to reset values immediately, and a subsequent LW 0x10 returns 0xA5AD1234 unchanged.

Source files
------------

// File: rtl/lsu32_pkg.sv
// Shared constants and helpers for the RV32I load/store unit.
// Latency: none; this file holds declarations and pure functions only.
// Backpressure: not applicable.
package lsu32_pkg;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Default size of the attached data memory, in 32-bit words
  localparam int LSU_DEPTH = 1024;

  // Transaction FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Misaligned access, or an encoding with no meaning for this direction.
  // Unsigned variants only exist for loads, so a store using them is illegal.
  function automatic logic lsu_misaligned(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = addr_lo[0];
      LSU_W:   bad = (addr_lo != 2'b00);
      LSU_BU:  bad = write;
      LSU_HU:  bad = write | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane32.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; results follow the inputs.
module lsu_lane32
  import lsu32_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  input  logic [n-1:0] mem_word,
  input  logic [n-1:0] store_data,
  output logic [n-1:0] load_data,
  output logic [n-1:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the fetched word
  always_comb begin
    sel_byte = 8'h00;
    case (addr_lo)
      2'd0: sel_byte = mem_word[7:0];
      2'd1: sel_byte = mem_word[15:8];
      2'd2: sel_byte = mem_word[23:16];
      2'd3: sel_byte = mem_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  // Sign- or zero-extend the selected lane to the full register width
  always_comb begin
    load_data = mem_word;
    case (funct3)
      LSU_B:   load_data = {{(n-8){sel_byte[7]}}, sel_byte};
      LSU_BU:  load_data = {{(n-8){1'b0}}, sel_byte};
      LSU_H:   load_data = {{(n-16){sel_half[15]}}, sel_half};
      LSU_HU:  load_data = {{(n-16){1'b0}}, sel_half};
      default: load_data = mem_word;
    endcase
  end

  // Overwrite only the addressed lane; the other lanes keep the fetched value
  always_comb begin
    merged_word = mem_word;
    case (funct3)
      LSU_B: begin
        case (addr_lo)
          2'd0: merged_word[7:0]   = store_data[7:0];
          2'd1: merged_word[15:8]  = store_data[7:0];
          2'd2: merged_word[23:16] = store_data[7:0];
          2'd3: merged_word[31:24] = store_data[7:0];
          default: merged_word = mem_word;
        endcase
      end
      LSU_H: begin
        if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
        else            merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit32.sv
// Single-outstanding RV32I load/store front end for a word-wide data memory.
// Latency: fault 1, load 2, SW 2, SB/SH 3 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; requests while busy are dropped; no response stall.
module load_store_unit32
  import lsu32_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH,
  parameter int n     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_misaligned,
  output logic         resp_oob,
  output logic [n-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [n-1:0] mem_write_data,
  input  logic [n-1:0] mem_read_data
);

  localparam logic [n-1:0] DEPTH_W = DEPTH[n-1:0];

  lsu_state_t   state, state_nxt;

  // Request fields kept for the lifetime of the transaction
  logic         write_q;
  logic [2:0]   funct3_q;
  logic [1:0]   addr_lo_q;
  logic [n-1:0] wdata_q;

  // Accept-time checks on the incoming request
  logic [n-1:0] word_idx;
  logic         acc_mis;
  logic         acc_oob;
  logic         acc_fault;
  logic         accept;

  logic [n-1:0] lane_load;
  logic [n-1:0] lane_merge;

  // Fault classification of the request on the bus this cycle
  always_comb begin
    word_idx  = {2'b00, req_addr[n-1:2]};
    acc_mis   = lsu_misaligned(req_write, req_funct3, req_addr[1:0]);
    acc_oob   = (word_idx >= DEPTH_W);
    acc_fault = acc_mis | acc_oob;
    accept    = req_valid & (state == ST_IDLE);
  end

  // Lane logic works on the live memory read; READ exit captures its result
  lsu_lane32 #(.n(n)) u_lane (
    .funct3      (funct3_q),
    .addr_lo     (addr_lo_q),
    .mem_word    (mem_read_data),
    .store_data  (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merge)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: faults skip memory; SW writes directly; loads and SB/SH read first
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (acc_fault)                            state_nxt = ST_RESP;
          else if (req_write && req_funct3 == LSU_W) state_nxt = ST_WRITE;
          else                                      state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake and write strobe, so reset drops them at once
  always_comb begin
    req_ready        = (state == ST_IDLE);
    resp_valid       = (state == ST_RESP);
    mem_write_enable = (state == ST_WRITE);
  end

  // Datapath: latch at accept, capture at READ exit, clear response after RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      addr_lo_q       <= 2'b00;
      wdata_q         <= '0;
      mem_addr        <= '0;
      mem_write_data  <= '0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_oob        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            write_q         <= req_write;
            funct3_q        <= req_funct3;
            addr_lo_q       <= req_addr[1:0];
            wdata_q         <= req_wdata;
            mem_addr        <= word_idx;
            // Flags only ever go high on the path that enters RESP directly
            resp_misaligned <= acc_mis;
            resp_oob        <= acc_oob;
            if (!acc_fault && req_write && req_funct3 == LSU_W)
              mem_write_data <= req_wdata;
          end
        end
        ST_READ: begin
          if (write_q) mem_write_data <= lane_merge;
          else         resp_rdata     <= lane_load;
        end
        ST_RESP: begin
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
          resp_oob        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
